// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the default sizes, the writeback requester indices and the width helpers
// used by the interface, the top level and the testbench.
package regfile_write_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
    localparam int unsigned DEFAULT_NUM_REGISTERS = 16;

    // Writeback requester indices
    localparam int unsigned WB_ALU         = 0;
    localparam int unsigned WB_MEM         = 1;
    localparam int unsigned WB_LINK        = 2;
    localparam int unsigned NUM_WB_SOURCES = 3;

    // Ceiling log2; clog2(0) = clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index width with a floor of one bit so single-entry cases stay legal
    function automatic int unsigned index_width(input int unsigned count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters and the arbiter, plus the register file write port.
//   master : requester side (drives stall, req_*; observes ready, rf_wr_*, grant_id, pending)
//   slave  : arbiter side
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    parameter int unsigned NUM_REQ       = NUM_WB_SOURCES
) ();
    localparam int unsigned ADDR_WIDTH = index_width(NUM_REGISTERS);
    localparam int unsigned ID_WIDTH   = index_width(NUM_REQ);

    logic                             stall;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             rf_wr_en;
    logic [ADDR_WIDTH-1:0]            rf_wr_addr;
    logic [DATA_WIDTH-1:0]            rf_wr_data;
    logic [ID_WIDTH-1:0]              grant_id;
    logic                             pending;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, grant_id, pending
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, grant_id, pending
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Round-robin priority picker: scans req_i starting at ptr_i and wrapping,
// returning the first set requester as a one-hot grant and a binary index.
//   req_i   : request vector
//   ptr_i   : scan start position (must be < N)
//   grant_o : one-hot winner
//   idx_o   : binary winner index
//   any_o   : at least one request present
module rr_priority_picker #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // First requester in rotated order wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the writeback sources
// (ALU, memory load return, link register) using round-robin arbitration.
// An accepted write is registered and appears on rf_wr_* the following cycle.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : requester handshake and register file write port (slave side)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    parameter int unsigned NUM_REQ       = NUM_WB_SOURCES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_write_arbiter_if.slave bus
);

    localparam int unsigned ADDR_WIDTH = index_width(NUM_REGISTERS);
    localparam int unsigned ID_WIDTH   = index_width(NUM_REQ);

    logic [NUM_REQ-1:0]    grant_c;
    logic [ID_WIDTH-1:0]   win_idx_c;
    logic                  win_any_c;
    logic                  accept_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_data_c;

    logic                  rf_wr_en_q,   rf_wr_en_d;
    logic [ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic [ID_WIDTH-1:0]   grant_id_q,   grant_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q,     rr_ptr_d;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (ID_WIDTH)
    ) u_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_c),
        .idx_o   (win_idx_c),
        .any_o   (win_any_c)
    );

    // Handshake is held off during reset so nothing looks accepted while flops are cleared
    assign accept_c      = win_any_c & ~bus.stall & reset_n;
    assign bus.req_ready = accept_c ? grant_c : '0;
    assign bus.pending   = reset_n & (|bus.req_valid) & ~accept_c;

    // One-hot AND-OR selection of the winning requester's slice
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_addr_c = sel_addr_c | bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_c = sel_data_c | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: load the write command on accept, otherwise hold everything but the enable
    always_comb begin
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (accept_c) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = sel_addr_c;
            rf_wr_data_d = sel_data_c;
            grant_id_d   = win_idx_c;
            rr_ptr_d     = (win_idx_c == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                 : win_idx_c + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_wr_addr = rf_wr_addr_q;
    assign bus.rf_wr_data = rf_wr_data_q;
    assign bus.grant_id   = grant_id_q;

endmodule
